dmem_responder: RTL and testbench

- Target-side responder for the core's data-memory request port (mem_req/mem_we/mem_waddr/mem_wdata/mem_raddr/mem_rdata).
- Serves word reads and writes from a local storage array with a configurable number of wait states.
- Returns a one-cycle ack and drives a hold request back to the pipeline control for the duration of each access.
- Replaces the zero-latency data memory when multi-cycle memory timing is modelled.

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle target for the core's data-memory port.
// Serves 32-bit word reads/writes from a local array after WAIT_CYCLES
// wait states, pulses mem_ack_o for one cycle and stalls the pipeline
// through hold_flag_o while an access is outstanding.
//
// Build option: define DMEM_RANGE_CHECK_EN to add mem_err_o and reject
// out-of-range or misaligned addresses instead of wrapping/truncating.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no access outstanding; a request is accepted and latched
// WAIT    | wait states counting down; access performed when count is 0
// RESP    | mem_ack_o (and mem_err_o) pulse; back to IDLE next cycle
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [31:0] mem_raddr_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        hold_flag_o,
`ifdef DMEM_RANGE_CHECK_EN
    output logic        mem_err_o,
`endif
    output logic        busy_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

    // Reject illegal parameterisations at elaboration time.
    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
    end
    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         wait_cnt;
    logic               accept;
    logic               commit;

    logic               lat_we;
    logic [IDX_W-1:0]   lat_idx;
    logic [31:0]        lat_wdata;
    logic               lat_err;

    logic [31:0]        sel_addr;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_err;

    logic [31:0]        mem [DEPTH_WORDS];

    // The address that matters depends on the direction of the request.
    assign sel_addr = mem_we_i ? mem_waddr_i : mem_raddr_i;
    assign sel_idx  = sel_addr[IDX_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    // Anything outside the array or not word aligned is an error.
    assign sel_err = (sel_addr[31:IDX_W+2] != '0) || (sel_addr[1:0] != 2'b00);
`else
    // Upper and byte-offset bits are deliberately discarded: addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sel_addr[31:IDX_W+2], sel_addr[1:0]};
    assign sel_err          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        commit      = 1'b0;
        mem_ack_o   = 1'b0;
        hold_flag_o = 1'b0;
        busy_o      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req_i) begin
                    accept      = 1'b1;
                    hold_flag_o = 1'b1;
                    state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy_o      = 1'b1;
                hold_flag_o = 1'b1;
                if (wait_cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                busy_o    = 1'b1;
                mem_ack_o = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // A reset cycle never stalls the pipeline nor acknowledges anything;
        // this is what suppresses the ack when reset lands in RESP.
        if (!rst) begin
            hold_flag_o = 1'b0;
            mem_ack_o   = 1'b0;
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    // Error flag travels with the ack of the flagged access.
    assign mem_err_o = mem_ack_o & lat_err;
`endif

    // Request latch, wait-state down-counter and read-data register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt    <= 4'd0;
            lat_we      <= 1'b0;
            lat_idx     <= '0;
            lat_wdata   <= 32'h0;
            lat_err     <= 1'b0;
            mem_rdata_o <= 32'h0;
        end else begin
            if (accept) begin
                wait_cnt  <= CNT_LOAD;
                lat_we    <= mem_we_i;
                lat_idx   <= sel_idx;
                lat_wdata <= mem_wdata_i;
                lat_err   <= sel_err;
            end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit && !lat_we) begin
                mem_rdata_o <= lat_err ? 32'h0 : mem[lat_idx];
            end
        end
    end

    // Storage array; never cleared, written only on a committed write.
    always_ff @(posedge clk) begin
        if (rst && commit && lat_we && !lat_err) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven directed accesses,
// hand-written multi-cycle corner cases and randomized traffic checked
// against a word-array reference model. Handles DMEM_RANGE_CHECK_EN builds.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned W     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        hold_flag;
    logic        busy;
`ifdef DMEM_RANGE_CHECK_EN
    logic        mem_err;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          churn;
        logic [31:0] exp_rd;
        bit          exp_err;
        string       name;
    } vec_t;

    vec_t tbl[$];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_waddr_i (mem_waddr),
        .mem_wdata_i (mem_wdata),
        .mem_raddr_i (mem_raddr),
        .mem_rdata_o (mem_rdata),
        .mem_ack_o   (mem_ack),
        .hold_flag_o (hold_flag),
`ifdef DMEM_RANGE_CHECK_EN
        .mem_err_o   (mem_err),
`endif
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    function automatic bit err_of(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return (a >= DEPTH * 4) || (a % 4 != 0);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // One complete access starting in an IDLE cycle; checks protocol,
    // latency, data and error, and updates the reference model.
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input bit churn, input logic [31:0] exp_rd, input bit exp_err,
                             input string name);
        int          lat = 0;
        bit          got = 0;
        bit          ok;
        logic [31:0] ack_rd = 32'h0;
        logic        ack_err = 1'b0;
        mem_req   = 1'b1;
        mem_we    = we;
        mem_waddr = we ? addr : $urandom;
        mem_raddr = we ? $urandom : addr;
        mem_wdata = wdata;
        #1;
        ok = (hold_flag === 1'b1) && (busy === 1'b0) && (mem_ack === 1'b0);
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (churn) begin
                mem_we    = 1'($urandom_range(0, 1));
                mem_waddr = $urandom;
                mem_raddr = $urandom;
                mem_wdata = $urandom;
            end
            #1;
            if (mem_ack === 1'b1) begin
                got    = 1;
                ack_rd = mem_rdata;
`ifdef DMEM_RANGE_CHECK_EN
                ack_err = mem_err;
`endif
                if (hold_flag !== 1'b0 || busy !== 1'b1) ok = 0;
            end else begin
                if (hold_flag !== 1'b1 || busy !== 1'b1) ok = 0;
`ifdef DMEM_RANGE_CHECK_EN
                if (mem_err !== 1'b0) ok = 0;
`endif
            end
        end
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();
        #1;
        if (mem_ack !== 1'b0 || busy !== 1'b0) ok = 0;
        check({name, " latency"}, lat, W + 1);
        check({name, " protocol"}, 32'(ok), 32'd1);
        if (!we) begin
            check({name, " rdata"}, ack_rd, exp_rd);
            last_rd = exp_rd;
        end else begin
            check({name, " rdata held"}, ack_rd, last_rd);
            if (!exp_err) ref_mem[idx_of(addr)] = wdata;
        end
`ifdef DMEM_RANGE_CHECK_EN
        check({name, " err"}, 32'(ack_err), 32'(exp_err));
`else
        if (ack_err !== 1'b0) check({name, " err"}, 32'(ack_err), 32'd0);
`endif
    endtask

    initial begin
        int          ack_cyc[3];
        int          n_acks;
        int          cyc;
        bit          saw_ack;
        bit          we;
        bit          churn;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] erd;
        bit          eerr;

        tbl.push_back('{1, 32'h0000_0010, 32'hDEADBEEF, 0, 32'h0, 0, "wr 0x10"});
        tbl.push_back('{0, 32'h0000_0010, 32'h0, 0, 32'hDEADBEEF, 0, "rd 0x10"});
        tbl.push_back('{1, 32'h0000_0000, 32'h1, 0, 32'h0, 0, "wr 0x0"});
        tbl.push_back('{1, 32'h0000_0004, 32'h2, 0, 32'h0, 0, "wr 0x4"});
        tbl.push_back('{1, 32'h0000_0008, 32'h3, 0, 32'h0, 0, "wr 0x8"});
        tbl.push_back('{1, 32'h0000_0020, 32'h0, 0, 32'h0, 0, "wr 0x20"});
        tbl.push_back('{1, 32'h0000_0030, 32'h12345678, 1, 32'h0, 0, "churn wr 0x30"});
        tbl.push_back('{0, 32'h0000_0030, 32'h0, 1, 32'h12345678, 0, "churn rd 0x30"});
`ifdef DMEM_RANGE_CHECK_EN
        tbl.push_back('{0, 32'h0000_0013, 32'h0, 0, 32'h0, 1, "rd misaligned"});
`else
        tbl.push_back('{0, 32'h0000_0013, 32'h0, 0, 32'hDEADBEEF, 0, "rd misaligned"});
`endif

        // Reset, with a request already pending to prove hold is masked.
        rst = 1'b0; mem_req = 1'b1; mem_we = 1'b0;
        mem_waddr = 32'h0; mem_raddr = 32'h0; mem_wdata = 32'h0;
        last_rd = 32'h0;
        tick(); tick();
        #1;
        check("reset ack", 32'(mem_ack), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset hold", 32'(hold_flag), 32'd0);
        check("reset rdata", mem_rdata, 32'h0);
        mem_req = 1'b0;
        rst = 1'b1;
        tick();

        foreach (tbl[i])
            do_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].churn,
                      tbl[i].exp_rd, tbl[i].exp_err, tbl[i].name);

        // Back-to-back reads with the request held continuously.
        mem_req = 1'b1; mem_we = 1'b0; mem_raddr = 32'h0;
        n_acks = 0; cyc = 0;
        #1;
        while (n_acks < 3 && cyc < 40) begin
            tick();
            cyc++;
            #1;
            if (mem_ack === 1'b1) begin
                ack_cyc[n_acks] = cyc;
                check("b2b rdata", mem_rdata, 32'(n_acks + 1));
                n_acks++;
                mem_raddr = 32'(n_acks * 4);
                if (n_acks == 3) mem_req = 1'b0;
            end
        end
        check("b2b ack count", 32'(n_acks), 32'd3);
        if (n_acks == 3) begin
            check("b2b first latency", 32'(ack_cyc[0]), W + 1);
            check("b2b spacing 1", 32'(ack_cyc[1] - ack_cyc[0]), W + 2);
            check("b2b spacing 2", 32'(ack_cyc[2] - ack_cyc[1]), W + 2);
        end
        last_rd = 32'h3;
        tick();

        // Reset in the second WAIT cycle of a write aborts it.
        mem_req = 1'b1; mem_we = 1'b1; mem_waddr = 32'h20; mem_wdata = 32'h55;
        tick();
        tick();
        rst = 1'b0; mem_req = 1'b0;
        #1;
        check("abort hold", 32'(hold_flag), 32'd0);
        saw_ack = mem_ack;
        tick();
        rst = 1'b1;
        repeat (5) begin
            #1;
            if (mem_ack !== 1'b0) saw_ack = 1;
            tick();
        end
        check("abort no ack", 32'(saw_ack), 32'd0);
        check("abort rdata cleared", mem_rdata, 32'h0);
        last_rd = 32'h0;
        do_access(0, 32'h20, 32'h0, 0, 32'h0, 0, "rd after abort");

        // Reset during RESP: write is kept, ack is swallowed.
        mem_req = 1'b1; mem_we = 1'b1; mem_waddr = 32'h24; mem_wdata = 32'h77;
        tick(); tick(); tick();
        rst = 1'b0; mem_req = 1'b0;
        #1;
        check("resp reset ack", 32'(mem_ack), 32'd0);
        tick();
        rst = 1'b1;
        ref_mem[idx_of(32'h24)] = 32'h77;
        tick();
        do_access(0, 32'h24, 32'h0, 0, 32'h77, 0, "rd after resp reset");

        // Address wrap / range check.
`ifdef DMEM_RANGE_CHECK_EN
        do_access(1, 32'h0000_4004, 32'hA5A5A5A5, 0, 32'h0, 1, "wr out of range");
        do_access(0, 32'h0000_0004, 32'h0, 0, 32'h2, 0, "rd 0x4 unchanged");
        do_access(0, 32'h0000_0006, 32'h0, 0, 32'h0, 1, "rd misaligned 0x6");
`else
        do_access(1, 32'h0000_4004, 32'hA5A5A5A5, 0, 32'h0, 0, "wr wrap");
        do_access(0, 32'h0000_0004, 32'h0, 0, 32'hA5A5A5A5, 0, "rd wrapped");
`endif

        // Randomized traffic over 16 words against the reference model.
        for (int i = 0; i < 16; i++)
            do_access(1, 32'(i * 4), $urandom, 0, 32'h0, 0, "preload");
        for (int i = 0; i < 60; i++) begin
            we    = 1'($urandom_range(0, 1));
            churn = 1'($urandom_range(0, 1));
            addr  = 32'($urandom_range(0, 15) * 4);
            case ($urandom_range(0, 7))
                0: addr = addr | (32'($urandom_range(1, 255)) << 14);
                1: addr = addr | 32'($urandom_range(1, 3));
                default: ;
            endcase
            wd   = $urandom;
            eerr = err_of(addr);
            erd  = eerr ? 32'h0 : ref_mem[idx_of(addr)];
            do_access(we, addr, wd, churn, erd, eerr, we ? "rand wr" : "rand rd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
